// File: rtl/rx_ascii_buffer.sv
// Receive buffer behind the 7E1 serial receiver: first-word-fall-through FIFO of
// {parity error, 7-bit ASCII} entries with sticky overflow and a saturating parity-error count.
module rx_ascii_buffer #(
  parameter int PROFUNDIDADE  = 8,
  parameter int N_PTR         = 3,
  parameter int DESCARTA_ERRO = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera,
  input  logic             pronto,
  input  logic [6:0]       dados_ascii,
  input  logic             par_ok,
  input  logic             le,
  output logic [6:0]       dado_saida,
  output logic             erro_saida,
  output logic             vazio,
  output logic             cheio,
  output logic [N_PTR:0]   ocupacao,
  output logic             overflow,
  output logic [7:0]       cont_erro_par
);

  logic [7:0]       mem [PROFUNDIDADE];
  logic [N_PTR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [N_PTR:0]   ocup_q, ocup_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       head;
  logic             push_cand, pop_ef, push_acc;

  assign vazio = (ocup_q == '0);
  assign cheio = (ocup_q == (N_PTR+1)'(PROFUNDIDADE));

  assign push_cand = pronto && (par_ok || DESCARTA_ERRO == 0);
  assign pop_ef    = le && !vazio;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_acc  = push_cand && (!cheio || pop_ef);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ocup_d   = ocup_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    if (zera) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ocup_d   = '0;
      ovf_d    = 1'b0;
      cnt_d    = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ef)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_acc, pop_ef})
        2'b10:   ocup_d = ocup_q + 1'b1;
        2'b01:   ocup_d = ocup_q - 1'b1;
        default: ocup_d = ocup_q;
      endcase
      if (push_cand && !push_acc) ovf_d = 1'b1;
      if (pronto && !par_ok && cnt_q != 8'hFF) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q   <= ocup_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push_acc && !zera) mem[wr_ptr_q] <= {~par_ok, dados_ascii};
  end

  assign head          = mem[rd_ptr_q];
  assign dado_saida    = vazio ? 7'h00 : head[6:0];
  assign erro_saida    = vazio ? 1'b0  : head[7];
  assign ocupacao      = ocup_q;
  assign overflow      = ovf_q;
  assign cont_erro_par = cnt_q;

endmodule

// File: tb/tb_rx_ascii_buffer.sv
// Bench for rx_ascii_buffer: table vectors, directed corner sequences and random traffic
// against a queue-based model, for both the keep-errors and discard-errors builds.
module tb_rx_ascii_buffer;

  logic       clock = 1'b0;
  logic       reset, zera, pronto, par_ok, le;
  logic [6:0] dados_ascii;

  logic [6:0] dado0, dado1;
  logic       err0, err1, vaz0, vaz1, chei0, chei1, ovf0, ovf1;
  logic [3:0] ocup0, ocup1;
  logic [7:0] cnt0, cnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  rx_ascii_buffer #(.PROFUNDIDADE(8), .N_PTR(3), .DESCARTA_ERRO(0)) dut0 (
    .clock(clock), .reset(reset), .zera(zera), .pronto(pronto), .dados_ascii(dados_ascii),
    .par_ok(par_ok), .le(le), .dado_saida(dado0), .erro_saida(err0), .vazio(vaz0),
    .cheio(chei0), .ocupacao(ocup0), .overflow(ovf0), .cont_erro_par(cnt0));

  rx_ascii_buffer #(.PROFUNDIDADE(8), .N_PTR(3), .DESCARTA_ERRO(1)) dut1 (
    .clock(clock), .reset(reset), .zera(zera), .pronto(pronto), .dados_ascii(dados_ascii),
    .par_ok(par_ok), .le(le), .dado_saida(dado1), .erro_saida(err1), .vazio(vaz1),
    .cheio(chei1), .ocupacao(ocup1), .overflow(ovf1), .cont_erro_par(cnt1));

  // Reference model: one queue of {erro, char} per build, shared parity counter.
  logic [7:0] q0[$], q1[$];
  logic       mov0, mov1;
  int         mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete();
    mov0 = 1'b0; mov1 = 1'b0; mcnt = 0;
  endtask

  task automatic model_one(inout logic [7:0] q[$], inout logic ov, input bit keep_err,
                           input bit pr, input logic [6:0] d, input bit p, input bit l);
    bit pop, cand;
    pop  = l && q.size() > 0;
    cand = pr && (p || keep_err);
    if (pop) void'(q.pop_front());
    if (cand) begin
      if (q.size() < 8) q.push_back({~p, d});
      else ov = 1'b1;
    end
  endtask

  task automatic model_step(input bit z, input bit pr, input logic [6:0] d, input bit p, input bit l);
    if (z) begin
      model_clear();
    end else begin
      model_one(q0, mov0, 1'b1, pr, d, p, l);
      model_one(q1, mov1, 1'b0, pr, d, p, l);
      if (pr && !p && mcnt < 255) mcnt++;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " dado0"}, dado0, q0.size() ? q0[0][6:0] : 7'h00);
    chk({tag, " erro0"}, err0,  q0.size() ? q0[0][7]   : 1'b0);
    chk({tag, " ocup0"}, ocup0, q0.size());
    chk({tag, " vazio0"}, vaz0, q0.size() == 0);
    chk({tag, " cheio0"}, chei0, q0.size() == 8);
    chk({tag, " ovf0"}, ovf0, mov0);
    chk({tag, " cnt0"}, cnt0, mcnt);
    chk({tag, " dado1"}, dado1, q1.size() ? q1[0][6:0] : 7'h00);
    chk({tag, " erro1"}, err1,  q1.size() ? q1[0][7]   : 1'b0);
    chk({tag, " ocup1"}, ocup1, q1.size());
    chk({tag, " vazio1"}, vaz1, q1.size() == 0);
    chk({tag, " cheio1"}, chei1, q1.size() == 8);
    chk({tag, " ovf1"}, ovf1, mov1);
    chk({tag, " cnt1"}, cnt1, mcnt);
  endtask

  // Drive one cycle of inputs, advance model and DUT, sample #1 after the edge.
  task automatic step(input bit z, input bit pr, input logic [6:0] d, input bit p, input bit l,
                      input string tag);
    zera = z; pronto = pr; dados_ascii = d; par_ok = p; le = l;
    model_step(z, pr, d, p, l);
    @(posedge clock); #1;
    zera = 1'b0; pronto = 1'b0; le = 1'b0;
    chk_model(tag);
  endtask

  typedef struct {
    bit z, pr; logic [6:0] d; bit p, l;
    logic [6:0] e_dado; bit e_err; logic [3:0] e_ocup; bit e_ovf; logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // z pr  d      p  l   dado   err occ ovf cnt   (keep-errors build)
    tbl[0] = '{0, 1, 7'h41, 1, 0, 7'h41, 0, 1, 0, 0};
    tbl[1] = '{0, 0, 7'h00, 1, 1, 7'h00, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 7'h41, 0, 0, 7'h41, 1, 1, 0, 1};
    tbl[3] = '{0, 1, 7'h42, 1, 1, 7'h42, 0, 1, 0, 1};
    tbl[4] = '{0, 0, 7'h00, 1, 1, 7'h00, 0, 0, 0, 1};
    tbl[5] = '{0, 0, 7'h00, 1, 1, 7'h00, 0, 0, 0, 1};
    tbl[6] = '{1, 1, 7'h43, 0, 1, 7'h00, 0, 0, 0, 0};
    tbl[7] = '{0, 1, 7'h44, 1, 1, 7'h44, 0, 1, 0, 0};
    tbl[8] = '{1, 0, 7'h00, 1, 0, 7'h00, 0, 0, 0, 0};

    reset = 1'b0; zera = 1'b0; pronto = 1'b0; dados_ascii = '0; par_ok = 1'b1; le = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    chk("reset vazio", vaz0, 1'b1);
    chk("reset ocup", ocup0, 4'd0);
    chk("reset dado", dado0, 7'h00);
    chk_model("reset");
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].z, tbl[i].pr, tbl[i].d, tbl[i].p, tbl[i].l, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d dado", i), dado0, tbl[i].e_dado);
      chk($sformatf("tbl%0d erro", i), err0, tbl[i].e_err);
      chk($sformatf("tbl%0d ocup", i), ocup0, tbl[i].e_ocup);
      chk($sformatf("tbl%0d ovf", i), ovf0, tbl[i].e_ovf);
      chk($sformatf("tbl%0d cnt", i), cnt0, tbl[i].e_cnt);
    end
    chk("discard build never queued bad char", vaz1, 1'b1);

    // Fill, overflow, drain in order
    for (int i = 0; i < 8; i++) step(0, 1, 7'(8'h30 + i), 1, 0, "fill");
    chk("fill cheio", chei0, 1'b1);
    chk("fill ocup", ocup0, 4'd8);
    step(0, 1, 7'h38, 1, 0, "ovf");
    chk("ovf flag", ovf0, 1'b1);
    chk("ovf ocup", ocup0, 4'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain order", dado0, 7'(8'h30 + i));
      step(0, 0, 7'h00, 1, 1, "drain");
    end
    chk("drain vazio", vaz0, 1'b1);
    chk("drain ovf sticky", ovf0, 1'b1);

    // Full with simultaneous push and pop, then wrap-around traffic
    step(1, 0, 7'h00, 1, 0, "zera");
    for (int i = 0; i < 8; i++) step(0, 1, 7'(8'h30 + i), 1, 0, "fill2");
    step(0, 1, 7'h5A, 1, 1, "fullpp");
    chk("fullpp head", dado0, 7'h31);
    chk("fullpp ocup", ocup0, 4'd8);
    chk("fullpp ovf", ovf0, 1'b0);
    step(1, 0, 7'h00, 1, 0, "zera");
    for (int i = 0; i < 4; i++) step(0, 1, 7'(8'h60 + i), 1, 0, "wpre");
    for (int i = 0; i < 12; i++) step(0, 1, 7'(8'h64 + i), 1, 1, "wrap");
    chk("wrap head", dado0, 7'h6C);

    // Parity counter saturation, then zera wins over pronto
    step(1, 0, 7'h00, 1, 0, "zera");
    for (int i = 0; i < 300; i++) step(0, 1, 7'($urandom), 0, 0, "sat");
    chk("sat cnt", cnt0, 8'd255);
    step(1, 1, 7'h55, 1, 0, "zera_pr");
    chk("zera cnt", cnt0, 8'd0);
    chk("zera vazio", vaz0, 1'b1);
    chk("zera ovf", ovf0, 1'b0);

    // Async reset between edges with entries queued
    for (int i = 0; i < 3; i++) step(0, 1, 7'(8'h70 + i), 1, 0, "rstq");
    #3 reset = 1'b0;
    #1;
    model_clear();
    chk("async vazio", vaz0, 1'b1);
    chk("async ocup", ocup0, 4'd0);
    chk("async dado", dado0, 7'h00);
    @(posedge clock); #1;
    reset = 1'b1;
    step(0, 0, 7'h00, 1, 1, "post_rst_le");
    chk("post reset vazio", vaz0, 1'b1);

    // Random traffic in phases biased toward filling and toward draining
    for (int i = 0; i < 2000; i++) begin
      int le_pct;
      le_pct = ((i / 250) % 2) ? 80 : 25;
      step(($urandom % 100) == 0, $urandom % 2, 7'($urandom), ($urandom % 4) != 0,
           ($urandom % 100) < le_pct, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
